// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory with 1-cycle read latency.
// Optional fetch anti-starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  typedef enum logic [1:0] {NONE, IF_RD, D_RD} owner_t;

  owner_t            state, state_next;
  logic              force_if;
  logic [DATA_W-1:0] if_hold, d_hold;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign force_if = if_req && (starve_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  starve_cnt <= '0;
    else if (!if_req || if_gnt) starve_cnt <= '0;
    else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants are masked by reset so nothing reaches the memory while rst is low.
  always_comb begin
    d_gnt  = rst && d_req && !force_if;
    if_gnt = rst && if_req && !d_gnt;
  end

  assign stall_if  = if_req && !if_gnt;
  assign mem_en    = if_gnt || d_gnt;
  assign mem_we    = d_gnt && d_we;
  assign mem_addr  = d_gnt ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= NONE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = NONE;
    if_valid   = 1'b0;
    d_valid    = 1'b0;
    if_rdata   = if_hold;
    d_rdata    = d_hold;
    if (if_gnt)              state_next = IF_RD;
    else if (d_gnt && !d_we) state_next = D_RD;
    case (state)
      IF_RD: begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
      end
      D_RD: begin
        d_valid = 1'b1;
        d_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  // Capture returned data so each rdata output holds between valid pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_hold <= '0;
      d_hold  <= '0;
    end else begin
      if (state == IF_RD) if_hold <= mem_rdata;
      if (state == D_RD)  d_hold  <= mem_rdata;
    end
  end

endmodule
